except_ctrl: RTL and testbench
==============================

# except_ctrl

Exception sequencer between the MEM stage and the CP0 register block. It prioritises per-instruction exception flags and pending interrupts, and waits for any outstanding data-bus transaction to drain. It then issues a one-cycle exception commit to CP0 (type, EPC source, delay-slot flag, bad address) together with a pipeline flush and the redirect PC. It owns the stall/flush sequencing so that CP0 only sees clean, single-cycle exception events.

## Interface
- EXC_VECTOR, 32'hBFC00380, redirect target for every exception except eret
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- valid_i  in  1  MEM-stage instruction valid
- pc_i  in  32  MEM-stage instruction address
- in_delayslot_i  in  1  MEM instruction is in a branch delay slot
- data_addr_i  in  32  MEM load/store effective address
- adel_if_i, ri_i, syscall_i, break_i, ov_i, trap_i, adel_ld_i, ades_i, eret_i  in  1 each  exception flags carried to MEM
- status_i  in  32  CP0 Status (IE bit0, EXL bit1, IM bits15:8)
- cause_i  in  32  CP0 Cause (IP bits15:8)
- epc_i  in  32  CP0 EPC, already forwarded for an in-flight mtc0 EPC
- bus_busy_i  in  1  data-bus transaction outstanding
- excepttype_o  out  32  CP0 exception code, nonzero for exactly one cycle per event
- current_inst_addr_o  out  32  PC of the excepting instruction
- is_in_delayslot_o  out  1  delay-slot flag for CP0
- bad_addr_o  out  32  BadVAddr value for CP0
- flush_o  out  1  flush all pipeline stages
- stall_o  out  1  freeze IF..MEM
- new_pc_o  out  32  redirect target, valid while flush_o=1

## Operation
- Interrupt pending: status_i[0]=1, status_i[1]=0, and (cause_i[15:8] & status_i[15:8]) != 0.
- Events are recognised only when valid_i=1. An interrupt with valid_i=0 waits for the next valid instruction.
- Priority, highest first, with codes:
  - interrupt 0x01
  - adel_if 0x04
  - ri 0x0a
  - syscall 0x08
  - break 0x09
  - ov 0x0c
  - trap 0x0d
  - adel_ld 0x04
  - ades 0x05
  - eret 0x0e
- bad_addr: pc_i for adel_if; data_addr_i for adel_ld/ades; 0 otherwise.
- new_pc: epc_i for eret; EXC_VECTOR for all other codes.
- FSM states IDLE, DRAIN, COMMIT.
- IDLE:
  - On an event, latch code, pc_i, in_delayslot_i, bad_addr and new_pc.
  - If bus_busy_i=1, go to DRAIN; else go to COMMIT.
  - No event: stay in IDLE.
- DRAIN: stall_o=1. All inputs except bus_busy_i are ignored. Move to COMMIT in the cycle after bus_busy_i is sampled 0.
- COMMIT (exactly one cycle):
  - excepttype_o = latched code, current_inst_addr_o/is_in_delayslot_o/bad_addr_o = latched values.
  - flush_o=1, stall_o=1, new_pc_o = latched target.
  - Next state is IDLE unconditionally.
- Outside COMMIT: excepttype_o=0, flush_o=0. current_inst_addr_o, is_in_delayslot_o, bad_addr_o and new_pc_o are 0.
- Flags raised while in DRAIN or COMMIT are dropped. The flush in COMMIT kills those instructions anyway.

## Timing
- Reset: state IDLE, every output 0, latches cleared. A reset asserted in DRAIN or COMMIT aborts the event with no commit pulse.
- Latency from an event sampled in IDLE with bus idle: excepttype_o/flush_o assert on the next cycle, for 1 cycle.
- Latency with the bus busy: COMMIT follows one cycle after the first sampled bus_busy_i=0. stall_o stays high throughout DRAIN and COMMIT.
- stall_o is a registered state decode: high in DRAIN and COMMIT, low in IDLE. It is not high in the detection cycle; MEM is flushed, not held.
- Back-to-back events: after COMMIT the block returns to IDLE and can detect an event in the following cycle. The earliest next commit is 2 cycles after the previous one.
- Simultaneous flags: the single highest-priority code wins. An interrupt preempts eret and everything else.

## Structure
- The shared defines header holds the exception code constants (EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS, EXC_BP, EXC_RI, EXC_OV, EXC_TR, EXC_ERET), the CP0 bit positions (IE, EXL, IM, IP) and the state encoding.
- Sub-module exc_prio_enc: a combinational priority encoder from flags + interrupt-pending to {hit, code, bad_addr_sel}. The FSM and latches stay in except_ctrl.

## Test plan
- syscall_i=1, valid_i=1, pc_i=0xBFC00100, bus idle -> next cycle excepttype_o=0x08, flush_o=1, new_pc_o=0xBFC00380, current_inst_addr_o=0xBFC00100; both drop the following cycle.
- ades_i=1, data_addr_i=0x80000003, bus_busy_i high for 3 cycles -> stall_o high 4 cycles, single excepttype_o=0x05 pulse with bad_addr_o=0x80000003, no earlier flush.
- status=0x00000401, cause IP2 set, ov_i=1 simultaneously -> code 0x01 (interrupt wins). With EXL=1 in status, the same stimulus -> code 0x0c.
- eret_i=1, epc_i=0xBFC00200 -> excepttype_o=0x0e, new_pc_o=0xBFC00200.
- adel_if_i=1, in_delayslot_i=1, pc_i=0xBFC00011 -> bad_addr_o=0xBFC00011, is_in_delayslot_o=1, code 0x04.
- rst asserted during DRAIN -> no excepttype_o pulse, all outputs 0 next cycle, a fresh event is handled normally afterwards.

Source files
------------

// File: rtl/except_ctrl_pkg.sv
// Shared constants and types for the exception sequencer: exception codes,
// CP0 bit positions, FSM state encoding and the latched event record.
package except_ctrl_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CODE_W = 5;

  localparam logic [XLEN-1:0] EXC_VECTOR = 32'hBFC00380;

  localparam logic [CODE_W-1:0] EXC_INT  = 5'h01;
  localparam logic [CODE_W-1:0] EXC_ADEL = 5'h04;
  localparam logic [CODE_W-1:0] EXC_ADES = 5'h05;
  localparam logic [CODE_W-1:0] EXC_SYS  = 5'h08;
  localparam logic [CODE_W-1:0] EXC_BP   = 5'h09;
  localparam logic [CODE_W-1:0] EXC_RI   = 5'h0a;
  localparam logic [CODE_W-1:0] EXC_OV   = 5'h0c;
  localparam logic [CODE_W-1:0] EXC_TR   = 5'h0d;
  localparam logic [CODE_W-1:0] EXC_ERET = 5'h0e;

  localparam int unsigned STATUS_IE  = 0;
  localparam int unsigned STATUS_EXL = 1;
  localparam int unsigned IM_LO      = 8;
  localparam int unsigned IM_HI      = 15;
  localparam int unsigned IP_LO      = 8;
  localparam int unsigned IP_HI      = 15;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    BAD_NONE = 2'd0,
    BAD_PC   = 2'd1,
    BAD_DATA = 2'd2
  } bad_sel_e;

  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic [XLEN-1:0]   pc;
    logic              in_ds;
    logic [XLEN-1:0]   bad_addr;
    logic [XLEN-1:0]   new_pc;
  } exc_rec_t;

  function automatic logic int_pending(input logic ie, input logic exl,
                                       input logic [7:0] im, input logic [7:0] ip);
    return ie && !exl && (|(im & ip));
  endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Combinational priority encoder: picks the single highest-priority exception
// among pending interrupt and MEM-stage flags.
module exc_prio_enc
  import except_ctrl_pkg::*;
(
  input  logic              int_pend_i,
  input  logic              adel_if_i,
  input  logic              ri_i,
  input  logic              syscall_i,
  input  logic              break_i,
  input  logic              ov_i,
  input  logic              trap_i,
  input  logic              adel_ld_i,
  input  logic              ades_i,
  input  logic              eret_i,
  output logic              hit_o,
  output logic [CODE_W-1:0] code_o,
  output bad_sel_e          bad_sel_o
);

  always_comb begin
    hit_o     = 1'b1;
    code_o    = '0;
    bad_sel_o = BAD_NONE;
    if (int_pend_i) begin
      code_o = EXC_INT;
    end else if (adel_if_i) begin
      code_o    = EXC_ADEL;
      bad_sel_o = BAD_PC;
    end else if (ri_i) begin
      code_o = EXC_RI;
    end else if (syscall_i) begin
      code_o = EXC_SYS;
    end else if (break_i) begin
      code_o = EXC_BP;
    end else if (ov_i) begin
      code_o = EXC_OV;
    end else if (trap_i) begin
      code_o = EXC_TR;
    end else if (adel_ld_i) begin
      code_o    = EXC_ADEL;
      bad_sel_o = BAD_DATA;
    end else if (ades_i) begin
      code_o    = EXC_ADES;
      bad_sel_o = BAD_DATA;
    end else if (eret_i) begin
      code_o = EXC_ERET;
    end else begin
      hit_o = 1'b0;
    end
  end

endmodule

// File: rtl/except_ctrl.sv
// Exception sequencer: detects an event in MEM, waits for the data bus to
// drain, then issues a single-cycle commit to CP0 with flush and redirect.
module except_ctrl
  import except_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            in_delayslot_i,
  input  logic [XLEN-1:0] data_addr_i,
  input  logic            adel_if_i,
  input  logic            ri_i,
  input  logic            syscall_i,
  input  logic            break_i,
  input  logic            ov_i,
  input  logic            trap_i,
  input  logic            adel_ld_i,
  input  logic            ades_i,
  input  logic            eret_i,
  input  logic [XLEN-1:0] status_i,
  input  logic [XLEN-1:0] cause_i,
  input  logic [XLEN-1:0] epc_i,
  input  logic            bus_busy_i,
  output logic [XLEN-1:0] excepttype_o,
  output logic [XLEN-1:0] current_inst_addr_o,
  output logic            is_in_delayslot_o,
  output logic [XLEN-1:0] bad_addr_o,
  output logic            flush_o,
  output logic            stall_o,
  output logic [XLEN-1:0] new_pc_o
);

  logic              int_pend;
  logic              enc_hit;
  logic [CODE_W-1:0] enc_code;
  bad_sel_e          enc_bad_sel;
  exc_rec_t          fresh;

  state_e   state_q, state_d;
  exc_rec_t rec_q, rec_d;

  logic [XLEN-1:0] excepttype_q, excepttype_d;
  logic [XLEN-1:0] cur_addr_q, cur_addr_d;
  logic            in_ds_q, in_ds_d;
  logic [XLEN-1:0] bad_addr_q, bad_addr_d;
  logic            flush_q, flush_d;
  logic            stall_q, stall_d;
  logic [XLEN-1:0] new_pc_q, new_pc_d;

  // Only IE/EXL/IM/IP participate in interrupt recognition.
  logic unused_cp0_bits;
  assign unused_cp0_bits = ^{status_i[XLEN-1:IM_HI+1], status_i[IM_LO-1:STATUS_EXL+1],
                             cause_i[XLEN-1:IP_HI+1], cause_i[IP_LO-1:0]};

  assign int_pend = int_pending(status_i[STATUS_IE], status_i[STATUS_EXL],
                                status_i[IM_HI:IM_LO], cause_i[IP_HI:IP_LO]);

  exc_prio_enc u_prio (
    .int_pend_i (int_pend),
    .adel_if_i  (adel_if_i),
    .ri_i       (ri_i),
    .syscall_i  (syscall_i),
    .break_i    (break_i),
    .ov_i       (ov_i),
    .trap_i     (trap_i),
    .adel_ld_i  (adel_ld_i),
    .ades_i     (ades_i),
    .eret_i     (eret_i),
    .hit_o      (enc_hit),
    .code_o     (enc_code),
    .bad_sel_o  (enc_bad_sel)
  );

  // Record captured at detection time.
  always_comb begin
    fresh.code  = enc_code;
    fresh.pc    = pc_i;
    fresh.in_ds = in_delayslot_i;
    unique case (enc_bad_sel)
      BAD_PC:   fresh.bad_addr = pc_i;
      BAD_DATA: fresh.bad_addr = data_addr_i;
      default:  fresh.bad_addr = '0;
    endcase
    fresh.new_pc = (enc_code == EXC_ERET) ? epc_i : EXC_VECTOR;
  end

  // Next state plus registered outputs derived from the state being entered.
  always_comb begin
    state_d      = state_q;
    rec_d        = rec_q;
    excepttype_d = '0;
    cur_addr_d   = '0;
    in_ds_d      = 1'b0;
    bad_addr_d   = '0;
    flush_d      = 1'b0;
    new_pc_d     = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (valid_i && enc_hit) begin
          rec_d   = fresh;
          state_d = bus_busy_i ? ST_DRAIN : ST_COMMIT;
        end
      end
      ST_DRAIN: begin
        if (!bus_busy_i) state_d = ST_COMMIT;
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase

    stall_d = (state_d != ST_IDLE);
    if (state_d == ST_COMMIT) begin
      excepttype_d = XLEN'(rec_d.code);
      cur_addr_d   = rec_d.pc;
      in_ds_d      = rec_d.in_ds;
      bad_addr_d   = rec_d.bad_addr;
      flush_d      = 1'b1;
      new_pc_d     = rec_d.new_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rec_q        <= '0;
      excepttype_q <= '0;
      cur_addr_q   <= '0;
      in_ds_q      <= 1'b0;
      bad_addr_q   <= '0;
      flush_q      <= 1'b0;
      stall_q      <= 1'b0;
      new_pc_q     <= '0;
    end else begin
      state_q      <= state_d;
      rec_q        <= rec_d;
      excepttype_q <= excepttype_d;
      cur_addr_q   <= cur_addr_d;
      in_ds_q      <= in_ds_d;
      bad_addr_q   <= bad_addr_d;
      flush_q      <= flush_d;
      stall_q      <= stall_d;
      new_pc_q     <= new_pc_d;
    end
  end

  assign excepttype_o        = excepttype_q;
  assign current_inst_addr_o = cur_addr_q;
  assign is_in_delayslot_o   = in_ds_q;
  assign bad_addr_o          = bad_addr_q;
  assign flush_o             = flush_q;
  assign stall_o             = stall_q;
  assign new_pc_o            = new_pc_q;

endmodule

// File: tb/tb_except_ctrl.sv
// Bench for except_ctrl: directed scenarios then random traffic, all checked
// against an event-level reference model.
module tb_except_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [31:0] pc_i;
  logic        in_delayslot_i;
  logic [31:0] data_addr_i;
  logic        adel_if_i, ri_i, syscall_i, break_i, ov_i, trap_i, adel_ld_i, ades_i, eret_i;
  logic [31:0] status_i, cause_i, epc_i;
  logic        bus_busy_i;
  logic [31:0] excepttype_o, current_inst_addr_o, bad_addr_o, new_pc_o;
  logic        is_in_delayslot_o, flush_o, stall_o;

  int n_checks = 0;
  int n_fail   = 0;

  except_ctrl dut (
    .clk                 (clk),
    .rst                 (rst),
    .valid_i             (valid_i),
    .pc_i                (pc_i),
    .in_delayslot_i      (in_delayslot_i),
    .data_addr_i         (data_addr_i),
    .adel_if_i           (adel_if_i),
    .ri_i                (ri_i),
    .syscall_i           (syscall_i),
    .break_i             (break_i),
    .ov_i                (ov_i),
    .trap_i              (trap_i),
    .adel_ld_i           (adel_ld_i),
    .ades_i              (ades_i),
    .eret_i              (eret_i),
    .status_i            (status_i),
    .cause_i             (cause_i),
    .epc_i               (epc_i),
    .bus_busy_i          (bus_busy_i),
    .excepttype_o        (excepttype_o),
    .current_inst_addr_o (current_inst_addr_o),
    .is_in_delayslot_o   (is_in_delayslot_o),
    .bad_addr_o          (bad_addr_o),
    .flush_o             (flush_o),
    .stall_o             (stall_o),
    .new_pc_o            (new_pc_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one pending event waiting for the bus, or one committing.
  bit          m_pending, m_commit;
  logic [31:0] m_code, m_pc, m_bad, m_npc;
  logic        m_ds;

  task automatic model_step();
    bit    had_commit;
    bit    flg[10];
    int    codes[10] = '{1, 4, 10, 8, 9, 12, 13, 4, 5, 14};
    int    hit;
    if (rst) begin
      m_pending = 0;
      m_commit  = 0;
      return;
    end
    had_commit = m_commit;
    m_commit   = 0;
    if (m_pending) begin
      if (!bus_busy_i) begin
        m_pending = 0;
        m_commit  = 1;
      end
    end else if (!had_commit && valid_i) begin
      flg[0] = status_i[0] && !status_i[1] && ((status_i[15:8] & cause_i[15:8]) != 8'h0);
      flg[1] = adel_if_i; flg[2] = ri_i;    flg[3] = syscall_i; flg[4] = break_i;
      flg[5] = ov_i;      flg[6] = trap_i;  flg[7] = adel_ld_i; flg[8] = ades_i;
      flg[9] = eret_i;
      hit = -1;
      for (int i = 9; i >= 0; i--) if (flg[i]) hit = i;
      if (hit >= 0) begin
        m_code = 32'(codes[hit]);
        m_pc   = pc_i;
        m_ds   = in_delayslot_i;
        m_bad  = (hit == 1) ? pc_i : ((hit == 7 || hit == 8) ? data_addr_i : 32'h0);
        m_npc  = (hit == 9) ? epc_i : 32'hBFC00380;
        if (bus_busy_i) m_pending = 1;
        else            m_commit  = 1;
      end
    end
  endtask

  // Advance one clock with the currently driven inputs and compare every output.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check("excepttype", excepttype_o,             m_commit ? m_code : 32'h0);
    check("inst_addr",  current_inst_addr_o,      m_commit ? m_pc   : 32'h0);
    check("delayslot",  32'(is_in_delayslot_o),   m_commit ? 32'(m_ds) : 32'h0);
    check("bad_addr",   bad_addr_o,               m_commit ? m_bad  : 32'h0);
    check("new_pc",     new_pc_o,                 m_commit ? m_npc  : 32'h0);
    check("flush",      32'(flush_o),             32'(m_commit));
    check("stall",      32'(stall_o),             32'(m_commit || m_pending));
  endtask

  task automatic clear_inputs();
    valid_i = 1'b0; in_delayslot_i = 1'b0;
    adel_if_i = 1'b0; ri_i = 1'b0; syscall_i = 1'b0; break_i = 1'b0; ov_i = 1'b0;
    trap_i = 1'b0; adel_ld_i = 1'b0; ades_i = 1'b0; eret_i = 1'b0;
    status_i = 32'h0; cause_i = 32'h0; bus_busy_i = 1'b0;
  endtask

  task automatic randomize_inputs();
    clear_inputs();
    rst            = ($urandom_range(0, 59) == 0);
    valid_i        = ($urandom_range(0, 3) != 0);
    pc_i           = $urandom;
    data_addr_i    = $urandom;
    epc_i          = $urandom;
    in_delayslot_i = $urandom_range(0, 1) == 1;
    adel_if_i = ($urandom_range(0, 15) == 0); ri_i    = ($urandom_range(0, 15) == 0);
    syscall_i = ($urandom_range(0, 15) == 0); break_i = ($urandom_range(0, 15) == 0);
    ov_i      = ($urandom_range(0, 15) == 0); trap_i  = ($urandom_range(0, 15) == 0);
    adel_ld_i = ($urandom_range(0, 15) == 0); ades_i  = ($urandom_range(0, 15) == 0);
    eret_i    = ($urandom_range(0, 15) == 0);
    status_i  = $urandom;
    status_i[1] = ($urandom_range(0, 3) == 0);
    cause_i   = ($urandom_range(0, 5) == 0) ? $urandom : ($urandom & 32'hFFFF00FF);
    bus_busy_i = ($urandom_range(0, 2) == 0);
  endtask

  initial begin
    clear_inputs();
    pc_i = 32'h0; data_addr_i = 32'h0; epc_i = 32'h0;
    m_pending = 0; m_commit = 0;
    m_code = 0; m_pc = 0; m_bad = 0; m_npc = 0; m_ds = 0;

    // Reset state.
    rst = 1'b1;
    cycle(); cycle();
    rst = 1'b0;
    cycle();

    // Syscall with bus idle: one-cycle commit on the next cycle.
    valid_i = 1'b1; syscall_i = 1'b1; pc_i = 32'hBFC00100;
    cycle();
    check("sys_code", excepttype_o, 32'h08);
    check("sys_pc",   current_inst_addr_o, 32'hBFC00100);
    check("sys_npc",  new_pc_o, 32'hBFC00380);
    clear_inputs();
    cycle();
    check("sys_drop", 32'(flush_o), 32'h0);

    // Store address error with bus busy for three sampled cycles.
    valid_i = 1'b1; ades_i = 1'b1; data_addr_i = 32'h80000003; bus_busy_i = 1'b1;
    cycle();
    clear_inputs(); bus_busy_i = 1'b1;
    cycle(); cycle();
    bus_busy_i = 1'b0;
    cycle();
    check("ades_code", excepttype_o, 32'h05);
    check("ades_bad",  bad_addr_o, 32'h80000003);
    cycle();

    // Interrupt preempts overflow; with EXL set overflow is taken instead.
    valid_i = 1'b1; ov_i = 1'b1; status_i = 32'h00000401; cause_i = 32'h00000400;
    cycle();
    check("int_code", excepttype_o, 32'h01);
    clear_inputs(); cycle();
    valid_i = 1'b1; ov_i = 1'b1; status_i = 32'h00000403; cause_i = 32'h00000400;
    cycle();
    check("ov_code", excepttype_o, 32'h0c);
    clear_inputs(); cycle();

    // eret redirects to EPC.
    valid_i = 1'b1; eret_i = 1'b1; epc_i = 32'hBFC00200;
    cycle();
    check("eret_code", excepttype_o, 32'h0e);
    check("eret_npc",  new_pc_o, 32'hBFC00200);
    clear_inputs(); cycle();

    // Fetch address error in a delay slot.
    valid_i = 1'b1; adel_if_i = 1'b1; in_delayslot_i = 1'b1; pc_i = 32'hBFC00011;
    cycle();
    check("adelif_code", excepttype_o, 32'h04);
    check("adelif_bad",  bad_addr_o, 32'hBFC00011);
    check("adelif_ds",   32'(is_in_delayslot_o), 32'h1);
    clear_inputs(); cycle();

    // Reset during DRAIN aborts the event; a later event still commits.
    valid_i = 1'b1; break_i = 1'b1; bus_busy_i = 1'b1;
    cycle();
    clear_inputs(); rst = 1'b1;
    cycle();
    check("rst_stall", 32'(stall_o), 32'h0);
    rst = 1'b0;
    cycle();
    check("rst_noexc", excepttype_o, 32'h0);
    valid_i = 1'b1; trap_i = 1'b1;
    cycle();
    check("post_rst_code", excepttype_o, 32'h0d);
    clear_inputs(); cycle();

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      randomize_inputs();
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
